// File: rtl/sdram_memtest.sv
`default_nettype none
// ============================================================================
// sdram_memtest : write-then-read-back pattern sweep over an SDRAM word range.
// Optional inverted second sweep when MEMTEST_INVPASS_EN is defined.
// Revision 1.0
// ============================================================================
module sdram_memtest #(
    parameter logic [20:0] ADDR_LAST = 21'h1FFFFF,
    parameter logic [15:0] TIMEOUT   = 16'd1023
) (
    input  logic        clk_p,
    input  logic        rst_n,
    input  logic        start,
    output logic        sdram_stb,
    output logic        sdram_we,
    output logic [1:0]  sdram_sel,
    output logic [20:0] sdram_adr,
    output logic [15:0] sdram_out,
    input  logic [15:0] sdram_dat,
    input  logic        sdram_ack,
    input  logic        sdram_ready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        tmo,
    output logic [20:0] err_adr,
    output logic [15:0] err_dat
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAITRDY = 3'd1,
        S_WR      = 3'd2,
        S_WR_GAP  = 3'd3,
        S_RD      = 3'd4,
        S_RD_GAP  = 3'd5,
        S_FIN     = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [20:0] adr_q, adr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rdat_q, rdat_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        tmo_q, tmo_d;
    logic [20:0] err_adr_q, err_adr_d;
    logic [15:0] err_dat_q, err_dat_d;

    logic [15:0] pattern;
    logic [15:0] cnt_inc;
    logic        last_adr;
    logic        expired;

`ifdef MEMTEST_INVPASS_EN
    logic inv_q, inv_d;
    assign pattern = (adr_q[15:0] ^ {11'b0, adr_q[20:16]}) ^ {16{inv_q}};
`else
    assign pattern = adr_q[15:0] ^ {11'b0, adr_q[20:16]};
`endif

    assign cnt_inc  = cnt_q + 16'd1;
    assign expired  = (cnt_inc >= TIMEOUT);
    assign last_adr = (adr_q == ADDR_LAST);

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        cnt_d     = 16'd0;
        rdat_d    = rdat_q;
        done_d    = done_q;
        pass_d    = pass_q;
        tmo_d     = tmo_q;
        err_adr_d = err_adr_q;
        err_dat_d = err_dat_q;
`ifdef MEMTEST_INVPASS_EN
        inv_d     = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAITRDY;
                    adr_d     = 21'd0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    tmo_d     = 1'b0;
                    err_adr_d = 21'd0;
                    err_dat_d = 16'd0;
`ifdef MEMTEST_INVPASS_EN
                    inv_d     = 1'b0;
`endif
                end
            end
            S_WAITRDY: begin
                if (sdram_ready) begin
                    state_d = S_WR;
                    adr_d   = 21'd0;
                end
            end
            S_WR, S_RD: begin
                if (sdram_ack) begin
                    state_d = (state_q == S_WR) ? S_WR_GAP : S_RD_GAP;
                    if (state_q == S_RD) rdat_d = sdram_dat;
                end else if (expired) begin
                    state_d   = S_FIN;
                    tmo_d     = 1'b1;
                    pass_d    = 1'b0;
                    done_d    = 1'b1;
                    err_adr_d = adr_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WR_GAP: begin
                // Terminal compare comes before the increment so the address never wraps.
                if (last_adr) begin
                    state_d = S_RD;
                    adr_d   = 21'd0;
                end else begin
                    state_d = S_WR;
                    adr_d   = adr_q + 21'd1;
                end
            end
            S_RD_GAP: begin
                if (rdat_q != pattern) begin
                    state_d   = S_FIN;
                    pass_d    = 1'b0;
                    done_d    = 1'b1;
                    err_adr_d = adr_q;
                    err_dat_d = rdat_q;
                end else if (last_adr) begin
`ifdef MEMTEST_INVPASS_EN
                    if (!inv_q) begin
                        state_d = S_WR;
                        adr_d   = 21'd0;
                        inv_d   = 1'b1;
                    end else begin
                        state_d = S_FIN;
                        pass_d  = 1'b1;
                        done_d  = 1'b1;
                    end
`else
                    state_d = S_FIN;
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = S_RD;
                    adr_d   = adr_q + 21'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            adr_q     <= 21'd0;
            cnt_q     <= 16'd0;
            rdat_q    <= 16'd0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            tmo_q     <= 1'b0;
            err_adr_q <= 21'd0;
            err_dat_q <= 16'd0;
`ifdef MEMTEST_INVPASS_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            cnt_q     <= cnt_d;
            rdat_q    <= rdat_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            tmo_q     <= tmo_d;
            err_adr_q <= err_adr_d;
            err_dat_q <= err_dat_d;
`ifdef MEMTEST_INVPASS_EN
            inv_q     <= inv_d;
`endif
        end
    end

    assign sdram_stb = (state_q == S_WR) || (state_q == S_RD);
    assign sdram_we  = (state_q == S_WR);
    assign sdram_sel = 2'b11;
    assign sdram_adr = adr_q;
    assign sdram_out = (state_q == S_WR) ? pattern : 16'd0;
    assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done      = done_q;
    assign pass      = pass_q;
    assign tmo       = tmo_q;
    assign err_adr   = err_adr_q;
    assign err_dat   = err_dat_q;

endmodule
`default_nettype wire

// File: doc/sdram_memtest.md
SDRAM_MEMTEST -- requirements
Module: sdram_memtest

Interface
REQ-001 Parameter ADDR_LAST, default 21'h1FFFFF, last word address tested (range 0..ADDR_LAST).
REQ-002 Parameter TIMEOUT, default 16'd1023, maximum clk_p cycles to wait for ack per transaction.
REQ-003 clk_p  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin a test run; sampled only in IDLE.
REQ-006 sdram_stb  out  1  transaction strobe toward the SDRAM bus responder.
REQ-007 sdram_we  out  1  1 = write, 0 = read.
REQ-008 sdram_sel  out  2  byte enables; always 2'b11.
REQ-009 sdram_adr  out  21  word address [21:1].
REQ-010 sdram_out  out  16  write data.
REQ-011 sdram_dat  in  16  read data; valid when sdram_ack = 1.
REQ-012 sdram_ack  in  1  transaction acknowledge.
REQ-013 sdram_ready  in  1  SDRAM initialisation complete.
REQ-014 busy / done / pass / tmo  out  1 each  running; finished; no error; finished by timeout.
REQ-015 err_adr  out  21  address of first failure; err_dat  out  16  data read at that address.

Function
REQ-016 Pattern P(a) = a[16:1] XOR {11'b0, a[21:17]}, 16 bits.
REQ-017 States: IDLE, WAITRDY, WR, WR_GAP, RD, RD_GAP, FIN.
REQ-018 IDLE: start=1 -> WAITRDY; clears done, pass, tmo, err_adr, err_dat; busy=1 from next cycle.
REQ-019 WAITRDY: stays until sdram_ready=1, then WR at address 0; no timeout in this state.
REQ-020 WR: sdram_stb=1, sdram_we=1, adr=a, out=P(a), all stable until sdram_ack sampled 1.
REQ-021 On ack in WR: stb=0 next cycle, state WR_GAP for exactly one cycle; a=ADDR_LAST -> RD at address 0, else a+1 -> WR.
REQ-022 RD: sdram_stb=1, sdram_we=0, adr=a, held until ack; sdram_dat captured on the same edge that samples ack.
REQ-023 Compare in RD_GAP: mismatch -> err_adr=a, err_dat=captured, pass=0, FIN; match and a=ADDR_LAST -> pass=1, FIN; else a+1 -> RD.
REQ-024 Strobe never stays asserted in consecutive transactions; at least one cycle with stb=0 between any two.
REQ-025 Per-transaction counter starts at 0 on stb rising; reaching TIMEOUT without ack -> stb=0, tmo=1, pass=0, err_adr=a, FIN.
REQ-026 ack while stb=0 is ignored.
REQ-027 FIN: busy=0, done=1; returns to IDLE on the next cycle; done, pass, tmo and err_* hold until the next start.
REQ-028 start while busy is ignored.
REQ-029 Address counter arithmetic 21 bits; wrap past ADDR_LAST never occurs (terminal compare precedes increment).

Reset
REQ-030 rst_n=0 forces IDLE asynchronously; all outputs 0 (sdram_sel=2'b11), counters 0.
REQ-031 Reset mid-transaction drops sdram_stb combinationally-free within the reset assertion; no partial result retained.

Configuration
REQ-032 Macro MEMTEST_INVPASS_EN defined: after a passing read sweep, a second write+read sweep with ~P(a) runs before FIN; pass=1 only if both sweeps pass.
REQ-033 MEMTEST_INVPASS_EN undefined: single sweep only; inverted-pass logic absent.

Verification
REQ-034 ADDR_LAST=7, ideal responder (ack 2 cycles after stb) -> 8 writes, 8 reads, pass=1, done=1, tmo=0.
REQ-035 ADDR_LAST=7, responder returns 16'h0000 at address 5 -> pass=0, err_adr=5, err_dat=16'h0000, no read of address 6.
REQ-036 TIMEOUT=15, responder never acks write at address 3 -> stb drops after 15 cycles, tmo=1, err_adr=3, done=1.
REQ-037 sdram_ready held 0 for 100 cycles after start -> stb stays 0 until ready=1, then run completes pass=1.
REQ-038 rst_n pulsed low during read of address 4 -> stb=0, busy=0, done=0; new start runs a full pass=1 test.
REQ-039 MEMTEST_INVPASS_EN defined, ADDR_LAST=3 -> 16 transactions; address 2 second-sweep data observed 16'hFFFD.
